pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 138 +++++++++++++
 tb/tb_pc_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/FETCH/EXEC/HALT control with branch, call/return and halt.
// Optional return stack enabled by defining MAK8_CALL_STACK_EN; without it call acts as a branch.
module pc_sequencer #(
    parameter int AW          = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] pc,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    output logic          instr_valid,
    input  logic          stall,
    input  logic          exec_done,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    input  logic          call,
    input  logic          ret,
    input  logic          halt,
    output logic [1:0]    state,
    output logic          stack_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    generate
        if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("STACK_DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_next;
    logic          retire;

    assign pc_inc    = pc + AW'(1);
    assign imem_req  = (state == S_FETCH) && !stall;
    assign imem_addr = pc;
    assign retire    = (state == S_EXEC) && exec_done && !stall;

`ifdef MAK8_CALL_STACK_EN
    localparam int SPW = $clog2(STACK_DEPTH);

    logic [AW-1:0] stack_mem [STACK_DEPTH];
    logic [SPW:0]  sp;
    logic [SPW:0]  sp_m1;
    logic          stk_full;
    logic          stk_empty;
    logic          do_push;
    logic          do_pop;
    logic          err_set;
    logic          err_q;

    assign sp_m1     = sp - (SPW + 1)'(1);
    assign stk_full  = (sp == (SPW + 1)'(STACK_DEPTH));
    assign stk_empty = (sp == '0);
    assign stack_err = err_q;

    always_comb begin
        pc_next = pc_inc;
        do_push = 1'b0;
        do_pop  = 1'b0;
        err_set = 1'b0;
        if (halt) begin
            pc_next = pc;
        end else if (ret) begin
            // Underflow falls through to the sequential address.
            if (stk_empty) err_set = 1'b1;
            else begin
                do_pop  = 1'b1;
                pc_next = stack_mem[sp_m1[SPW-1:0]];
            end
        end else if (call) begin
            pc_next = br_target;
            if (stk_full) err_set = 1'b1;
            else          do_push = 1'b1;
        end else if (br_taken) begin
            pc_next = br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp    <= '0;
            err_q <= 1'b0;
        end else if (retire) begin
            if (do_push) sp <= sp + (SPW + 1)'(1);
            if (do_pop)  sp <= sp_m1;
            if (err_set) err_q <= 1'b1;
        end
    end

    // Storage is not reset; sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && retire && do_push) stack_mem[sp[SPW-1:0]] <= pc_inc;
    end
`else
    assign stack_err = 1'b0;

    always_comb begin
        pc_next = pc_inc;
        if (halt)                      pc_next = pc;
        else if (ret)                  pc_next = pc_inc;
        else if (call || br_taken)     pc_next = br_target;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            instr_valid <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (!stall && imem_ack) begin
                        state       <= S_EXEC;
                        instr_valid <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (retire) begin
                        pc    <= pc_next;
                        state <= halt ? S_HALT : S_FETCH;
                    end
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; stack checks follow MAK8_CALL_STACK_EN.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic        stall;
    logic        exec_done;
    logic        br_taken;
    logic [15:0] br_target;
    logic        call;
    logic        ret;
    logic        halt;
    logic [1:0]  state;
    logic        stack_err;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.AW(16), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .instr_valid(instr_valid), .stall(stall),
        .exec_done(exec_done), .br_taken(br_taken), .br_target(br_target),
        .call(call), .ret(ret), .halt(halt), .state(state), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ins();
        stall = 0; exec_done = 0; br_taken = 0; br_target = '0;
        call = 0; ret = 0; halt = 0; imem_ack = 0;
    endtask

    // Reset for 3 cycles, release, land in FETCH.
    task automatic do_reset();
        clear_ins();
        rst = 1;
        repeat (3) tick();
        rst = 0;
        tick();
    endtask

    // From FETCH: fetch one instruction, then retire it with the given qualifiers.
    task automatic exec_op(input logic c, input logic r, input logic b, input logic h,
                           input logic [15:0] tgt);
        imem_ack = 1; exec_done = 0;
        tick();
        exec_done = 1; call = c; ret = r; br_taken = b; halt = h; br_target = tgt;
        tick();
        exec_done = 0; call = 0; ret = 0; br_taken = 0; halt = 0;
    endtask

    task automatic test_reset();
        clear_ins();
        rst = 1;
        repeat (3) tick();
        checks++;
        if (pc !== 16'h0 || state !== 2'd0 || imem_req !== 1'b0 || instr_valid !== 1'b0 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state pc=%h state=%0d req=%b iv=%b err=%b want 0000/0/0/0/0",
                     pc, state, imem_req, instr_valid, stack_err);
        end
        rst = 0;
        tick();
        checks++;
        if (state !== 2'd1 || imem_req !== 1'b1 || imem_addr !== 16'h0) begin
            errors++;
            $display("FAIL idle_to_fetch state=%0d req=%b addr=%h want 1/1/0000", state, imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [15:0] seen [4];
        int n = 0;
        int pulses = 0;
        do_reset();
        imem_ack = 1; exec_done = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (instr_valid === 1'b1) pulses++;
            if (state === 2'd2 && n < 4) begin
                seen[n] = pc;
                n++;
            end
        end
        checks++;
        if (n != 4 || seen[0] !== 16'd0 || seen[1] !== 16'd1 || seen[2] !== 16'd2 || seen[3] !== 16'd3) begin
            errors++;
            $display("FAIL seq_pc n=%0d pcs=%h,%h,%h,%h want 4 execs 0,1,2,3", n, seen[0], seen[1], seen[2], seen[3]);
        end
        checks++;
        if (pulses != 4) begin
            errors++;
            $display("FAIL instr_valid_pulses got %0d want 4", pulses);
        end
        exec_done = 0;
    endtask

    task automatic test_fetch_wait();
        // In FETCH at pc=4 after the sequential run.
        imem_ack = 1; stall = 1;
        tick();
        checks++;
        if (state !== 2'd1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_stall state=%0d req=%b want 1/0", state, imem_req);
        end
        stall = 0; imem_ack = 0;
        repeat (2) tick();
        checks++;
        if (state !== 2'd1 || imem_req !== 1'b1 || imem_addr !== 16'd4) begin
            errors++;
            $display("FAIL fetch_wait state=%0d req=%b addr=%h want 1/1/0004", state, imem_req, imem_addr);
        end
    endtask

    task automatic test_branch_stall();
        exec_op(0, 0, 0, 0, 16'h0);
        imem_ack = 1;
        tick();
        checks++;
        if (state !== 2'd2 || pc !== 16'h0005) begin
            errors++;
            $display("FAIL exec_at_5 state=%0d pc=%h want 2/0005", state, pc);
        end
        exec_done = 1; br_taken = 1; br_target = 16'h0100; stall = 1;
        repeat (2) tick();
        checks++;
        if (state !== 2'd2 || pc !== 16'h0005 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL exec_stall_hold state=%0d pc=%h iv=%b want 2/0005/0", state, pc, instr_valid);
        end
        stall = 0;
        tick();
        exec_done = 0; br_taken = 0;
        checks++;
        if (state !== 2'd1 || pc !== 16'h0100 || imem_addr !== 16'h0100 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL branch_redirect state=%0d pc=%h addr=%h req=%b want 1/0100/0100/1",
                     state, pc, imem_addr, imem_req);
        end
    endtask

    task automatic test_exec_hold_and_wrap();
        imem_ack = 1;
        tick();
        repeat (2) tick();
        checks++;
        if (state !== 2'd2 || pc !== 16'h0100) begin
            errors++;
            $display("FAIL exec_wait state=%0d pc=%h want 2/0100", state, pc);
        end
        exec_done = 1; br_taken = 1; br_target = 16'hFFFF;
        tick();
        exec_done = 0; br_taken = 0;
        exec_op(0, 0, 0, 0, 16'h1234);
        checks++;
        if (state !== 2'd1 || pc !== 16'h0000 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL pc_wrap state=%0d pc=%h addr=%h want 1/0000/0000", state, pc, imem_addr);
        end
    endtask

    task automatic test_call_ret();
        do_reset();
`ifdef MAK8_CALL_STACK_EN
        exec_op(0, 0, 1, 0, 16'h0010);
        exec_op(1, 0, 0, 0, 16'h0200);
        checks++;
        if (pc !== 16'h0200) begin
            errors++;
            $display("FAIL call_target pc=%h want 0200", pc);
        end
        exec_op(0, 1, 0, 0, 16'h0);
        checks++;
        if (pc !== 16'h0011 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL ret_pop pc=%h err=%b want 0011/0", pc, stack_err);
        end
        for (int i = 0; i < 4; i++) exec_op(1, 0, 0, 0, 16'h0300);
        checks++;
        if (stack_err !== 1'b0) begin
            errors++;
            $display("FAIL stack_fill_err err=%b want 0", stack_err);
        end
        exec_op(1, 0, 0, 0, 16'h0300);
        checks++;
        if (stack_err !== 1'b1 || pc !== 16'h0300) begin
            errors++;
            $display("FAIL stack_overflow err=%b pc=%h want 1/0300", stack_err, pc);
        end
        for (int i = 0; i < 4; i++) exec_op(0, 1, 0, 0, 16'h0);
        checks++;
        if (pc !== 16'h0012 || stack_err !== 1'b1) begin
            errors++;
            $display("FAIL unwind pc=%h err=%b want 0012/1", pc, stack_err);
        end
        do_reset();
        exec_op(0, 1, 0, 0, 16'h0);
        checks++;
        if (pc !== 16'h0001 || stack_err !== 1'b1) begin
            errors++;
            $display("FAIL stack_underflow pc=%h err=%b want 0001/1", pc, stack_err);
        end
`else
        exec_op(1, 0, 0, 0, 16'h0200);
        checks++;
        if (pc !== 16'h0200) begin
            errors++;
            $display("FAIL call_as_branch pc=%h want 0200", pc);
        end
        exec_op(0, 1, 0, 0, 16'h0);
        checks++;
        if (pc !== 16'h0201 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL ret_as_seq pc=%h err=%b want 0201/0", pc, stack_err);
        end
        exec_op(0, 1, 1, 0, 16'h0700);
        checks++;
        if (pc !== 16'h0202) begin
            errors++;
            $display("FAIL ret_over_branch pc=%h want 0202", pc);
        end
`endif
    endtask

    task automatic test_halt();
        do_reset();
        exec_op(0, 0, 1, 0, 16'h0040);
        exec_op(1, 1, 1, 1, 16'h0999);
        checks++;
        if (state !== 2'd3 || pc !== 16'h0040 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter state=%0d pc=%h req=%b want 3/0040/0", state, pc, imem_req);
        end
        imem_ack = 1; exec_done = 1;
        repeat (6) tick();
        exec_done = 0;
        checks++;
        if (state !== 2'd3 || pc !== 16'h0040 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_stuck state=%0d pc=%h req=%b iv=%b want 3/0040/0/0", state, pc, imem_req, instr_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        exec_op(0, 0, 1, 0, 16'h0077);
        imem_ack = 1;
        tick();
        rst = 1; exec_done = 1;
        tick();
        checks++;
        if (pc !== 16'h0 || state !== 2'd0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_exec pc=%h state=%0d iv=%b want 0000/0/0", pc, state, instr_valid);
        end
        rst = 0; exec_done = 0; imem_ack = 0;
        tick();
        exec_op(0, 0, 1, 0, 16'h0055);
        rst = 1; imem_ack = 1;
        tick();
        rst = 0;
        checks++;
        if (pc !== 16'h0 || state !== 2'd0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_fetch pc=%h state=%0d req=%b want 0000/0/0", pc, state, imem_req);
        end
    endtask

    initial begin
        clear_ins();
        rst = 1;
        test_reset();
        test_sequential();
        test_fetch_wait();
        test_branch_stall();
        test_exec_hold_and_wrap();
        test_call_ret();
        test_halt();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
